// File: rtl/seg_capture.sv
// seg_capture: rebuilds the 16-bit hex value and the four dot flags from a
// scanned, active-low one-cold 4-digit seven-segment bus. Each complete frame
// is published with a one-cycle data_valid pulse. A watchdog raises link_lost
// when no frame has been committed for TIMEOUT_CYC cycles.
// Optional feature: define SEG_CAPTURE_CHANGE_ONLY_EN so that data_valid pulses
// only when a committed frame differs from the one already on the outputs.
module seg_capture #(
  parameter logic [15:0] SETTLE_CYC  = 16'd8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  seg_sel,
  input  logic [7:0]  seg_led,
  output logic [15:0] data_out,
  output logic [3:0]  point_out,
  output logic        data_valid,
  output logic        pat_err,
  output logic        seq_err,
  output logic        link_lost
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLED} state_t;

  // True when exactly one digit select line is low.
  function automatic logic one_cold(input logic [3:0] s);
    logic r;
    case (s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Reverse glyph decode: {valid, nibble}; unknown patterns give nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [3:0]  sel_meta_reg, sel_sync_reg, sel_prev_reg;
  logic [7:0]  led_meta_reg, led_sync_reg;
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [3:0]  seen_reg, seen_next;
  logic [23:0] wd_reg, wd_next;
  logic [15:0] data_out_reg;
  logic [3:0]  point_out_reg;
  logic        data_valid_reg, pat_err_reg, seq_err_reg;

  logic        sel_change;
  logic        sample;
  logic        commit;
  logic        frame_changed;
  logic [3:0]  slot_hit;
  logic [3:0]  seen_base;
  logic [4:0]  decoded;
  logic [15:0] shadow_data;
  logic [3:0]  shadow_point;

  // Two-flop synchronisers for the asynchronous scan bus.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_meta_reg <= 4'b1111;
      sel_sync_reg <= 4'b1111;
      led_meta_reg <= 8'h00;
      led_sync_reg <= 8'h00;
    end else begin
      sel_meta_reg <= seg_sel;
      sel_sync_reg <= sel_meta_reg;
      led_meta_reg <= seg_led;
      led_sync_reg <= led_meta_reg;
    end
  end

  assign sel_change = (sel_sync_reg != sel_prev_reg);

  // Dwell tracker state register: previous select, settle counter, state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_prev_reg <= 4'b1111;
      state_reg    <= IDLE;
      cnt_reg      <= 16'd0;
    end else begin
      sel_prev_reg <= sel_sync_reg;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Next-state logic: any select change restarts the dwell; a settled dwell
  // is sampled exactly once.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sample     = 1'b0;
    if (sel_change) begin
      cnt_next   = 16'd0;
      state_next = one_cold(sel_sync_reg) ? SETTLE : IDLE;
    end else begin
      case (state_reg)
        IDLE: cnt_next = 16'd0;
        SETTLE: begin
          if (cnt_reg == SETTLE_CYC) begin
            sample     = 1'b1;
            state_next = SAMPLED;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        SAMPLED: state_next = SAMPLED;
        default: state_next = IDLE;
      endcase
    end
  end

  assign decoded   = decode(led_sync_reg[6:0]);
  assign slot_hit  = sample ? ~sel_prev_reg : 4'b0000;
  assign commit    = (seen_reg == 4'b1111);
  // A commit and a sample may coincide; the sample lands in the cleared set.
  assign seen_base = commit ? 4'b0000 : seen_reg;
  assign seen_next = seen_base | slot_hit;

`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
  assign frame_changed = ({shadow_point, shadow_data} != {point_out_reg, data_out_reg});
`else
  assign frame_changed = 1'b1;
`endif

  // Per-digit shadow registers, written when that digit is sampled.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [3:0] nib_reg;
      logic       dot_reg;
      // Capture nibble and dot for this digit on its sample.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          nib_reg <= 4'h0;
          dot_reg <= 1'b0;
        end else if (slot_hit[gi]) begin
          nib_reg <= decoded[3:0];
          dot_reg <= led_sync_reg[7];
        end
      end
      assign shadow_data[4*gi +: 4] = nib_reg;
      assign shadow_point[gi]       = dot_reg;
    end
  endgenerate

  // Frame assembly, commit, error pulses and watchdog.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seen_reg       <= 4'b0000;
      data_out_reg   <= 16'h0000;
      point_out_reg  <= 4'b0000;
      data_valid_reg <= 1'b0;
      pat_err_reg    <= 1'b0;
      seq_err_reg    <= 1'b0;
      wd_reg         <= 24'd0;
    end else begin
      seen_reg       <= seen_next;
      pat_err_reg    <= sample & ~decoded[4];
      seq_err_reg    <= |(seen_base & slot_hit);
      data_valid_reg <= commit & frame_changed;
      wd_reg         <= wd_next;
      if (commit) begin
        data_out_reg  <= shadow_data;
        point_out_reg <= shadow_point;
      end
    end
  end

  // Watchdog counter saturates at the timeout and restarts on every commit.
  always_comb begin
    wd_next = wd_reg;
    if (commit)
      wd_next = 24'd0;
    else if (wd_reg != TIMEOUT_CYC)
      wd_next = wd_reg + 24'd1;
  end

  assign data_out   = data_out_reg;
  assign point_out  = point_out_reg;
  assign data_valid = data_valid_reg;
  assign pat_err    = pat_err_reg;
  assign seq_err    = seq_err_reg;
  assign link_lost  = (wd_reg == TIMEOUT_CYC);

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: directed and random scan dwells checked cycle by
// cycle against a dwell-level reference model of the capture rules.
module tb_seg_capture;
  localparam int S = 8;
  localparam int T = 300;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  seg_sel = 4'hF;
  logic [7:0]  seg_led = 8'h00;
  logic [15:0] data_out;
  logic [3:0]  point_out;
  logic        data_valid, pat_err, seq_err, link_lost;

  seg_capture #(.SETTLE_CYC(16'(S)), .TIMEOUT_CYC(24'(T))) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .seg_sel(seg_sel), .seg_led(seg_led),
    .data_out(data_out), .point_out(point_out), .data_valid(data_valid),
    .pat_err(pat_err), .seq_err(seq_err), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [3:0]  seen_m;
  logic [3:0]  nib_m [4];
  logic        dot_m [4];
  logic [15:0] data_m;
  logic [3:0]  point_m;
  int          wd_m;
  logic [3:0]  last_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (glyph[k] == p) return k;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] sel);
    if ($countones(~sel) != 1) return -1;
    for (int k = 0; k < 4; k++) if (!sel[k]) return k;
    return -1;
  endfunction

  task automatic model_clear();
    seen_m = 4'h0; data_m = 16'h0; point_m = 4'h0; wd_m = 0; last_sel = 4'hF;
    for (int k = 0; k < 4; k++) begin nib_m[k] = 4'h0; dot_m[k] = 1'b0; end
  endtask

  // Called just after a posedge; asserts reset and checks reset values.
  task automatic do_reset();
    sys_rst_n = 1'b0; seg_sel = 4'hF; seg_led = 8'h00;
    #2;
    check("rst_data_out", data_out, 16'h0000);
    check("rst_point_out", point_out, 4'h0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_pat_err", pat_err, 1'b0);
    check("rst_seq_err", seq_err, 1'b0);
    check("rst_link_lost", link_lost, 1'b0);
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    model_clear();
  endtask

  // One dwell of len edges. One-cold dwells must be either long (>= S+6)
  // or short (<= S-1); long ones are sampled S+3 edges after the first edge.
  task automatic dwell(input logic [3:0] sel, input logic [7:0] led, input int len);
    int slot, idx;
    bit sampled, pend, commit;
    logic exp_pat, exp_seq, exp_dv;
    logic [15:0] nd;
    logic [3:0]  np;
    seg_sel = sel; seg_led = led; last_sel = sel;
    slot = slot_of(sel);
    sampled = (slot >= 0) && (len >= S + 6);
    pend = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      exp_pat = 0; exp_seq = 0; exp_dv = 0; commit = 0;
      if (sampled && i == S + 3) begin
        idx = lookup(led[6:0]);
        exp_pat = (idx < 0);
        if (idx < 0) idx = 0;
        exp_seq = seen_m[slot];
        nib_m[slot] = 4'(idx);
        dot_m[slot] = led[7];
        seen_m[slot] = 1'b1;
        if (seen_m == 4'hF) pend = 1;
      end
      if (pend && i == S + 4) begin
        pend = 0;
        for (int k = 0; k < 4; k++) begin nd[4*k +: 4] = nib_m[k]; np[k] = dot_m[k]; end
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
        exp_dv = ({np, nd} != {point_m, data_m});
`else
        exp_dv = 1'b1;
`endif
        data_m = nd; point_m = np; seen_m = 4'h0; commit = 1;
      end
      wd_m = commit ? 0 : ((wd_m < T) ? wd_m + 1 : T);
      #1;
      check("pat_err", pat_err, exp_pat);
      check("seq_err", seq_err, exp_seq);
      check("data_valid", data_valid, exp_dv);
      check("link_lost", link_lost, (wd_m == T));
      check("data_out", data_out, data_m);
      check("point_out", point_out, point_m);
    end
  endtask

  task automatic frame(input logic [15:0] d, input logic [3:0] p, input int len);
    logic [3:0] sel;
    for (int n = 0; n < 4; n++) begin
      sel = 4'hF; sel[n] = 1'b0;
      dwell(sel, {p[n], glyph[d[4*n +: 4]]}, len);
    end
  endtask

  initial begin
    logic [3:0] sel_tab [6] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hC, 4'hF};
    logic [3:0] sel;
    logic [7:0] led;
    int len;

    do_reset();

    // Basic frame, twice
    frame(16'h1A2F, 4'b0100, 50);
    check("frame1_data", data_out, 16'h1A2F);
    check("frame1_point", point_out, 4'b0100);
    frame(16'h1A2F, 4'b0100, 50);

    // Invalid glyph on digit 1
    dwell(4'hE, {1'b0, glyph[4'h3]}, 50);
    dwell(4'hD, 8'h00, 50);
    dwell(4'hB, {1'b1, glyph[4'h7]}, 50);
    dwell(4'h7, {1'b0, glyph[4'hC]}, 50);
    check("pat_frame_data", data_out, 16'hC703);
    check("pat_frame_point", point_out, 4'b0100);

    // Out-of-order with repeated digit 0
    dwell(4'hE, {1'b0, glyph[4'h5]}, 50);
    dwell(4'hD, {1'b0, glyph[4'h6]}, 50);
    dwell(4'hE, {1'b1, glyph[4'h9]}, 50);
    dwell(4'hB, {1'b0, glyph[4'hB]}, 50);
    dwell(4'h7, {1'b0, glyph[4'hE]}, 50);
    check("seq_frame_data", data_out, 16'hEB69);
    check("seq_frame_point", point_out, 4'b0001);

    // Glitch dwells and non-one-cold selects: nothing sampled
    dwell(4'hE, {1'b0, glyph[4'h1]}, S - 1);
    dwell(4'hC, {1'b0, glyph[4'h2]}, 40);
    dwell(4'hD, {1'b0, glyph[4'h3]}, S - 1);
    dwell(4'hF, 8'h00, 10);
    dwell(4'hB, 8'hFF, S - 1);
    frame(16'h4D0B, 4'b1001, 30);

    // Random dwells
    for (int r = 0; r < 40; r++) begin
      do sel = sel_tab[$urandom_range(0, 5)]; while (sel == last_sel);
      if ($urandom_range(0, 3) == 0) led = 8'($urandom);
      else led = {1'($urandom), glyph[$urandom_range(0, 15)]};
      if (slot_of(sel) >= 0)
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S + 6, S + 30);
      else
        len = $urandom_range(1, 30);
      dwell(sel, led, len);
    end

    // Scan stops: link_lost, then recovery on the next frame
    dwell(4'hF, 8'h00, T + 20);
    check("timeout_link_lost", link_lost, 1'b1);
    frame(16'h5A5A, 4'b1010, 50);
    check("recover_link_lost", link_lost, 1'b0);

    // Reset mid-frame, then an all-zero frame
    dwell(4'hE, {1'b1, glyph[4'h8]}, 50);
    dwell(4'hD, {1'b1, glyph[4'h9]}, 50);
    do_reset();
    frame(16'h0000, 4'b0000, 50);
    check("zero_frame_data", data_out, 16'h0000);
    check("zero_frame_point", point_out, 4'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side counterpart of the 4-digit multiplexed seven-segment scan driver. It watches the scanned `seg_sel`/`seg_led` bus and rebuilds the 16-bit hex value and the 4 decimal-point flags that the driver is showing. It publishes each complete frame with a one-cycle `data_valid` pulse. It serves as the loop-back checker on the board and as a scoreboard front end in display verification.

## Interface
- `SETTLE_CYC`, 16'd8: cycles a digit select must stay stable before `seg_led` is sampled; legal range 1..65535.
- `TIMEOUT_CYC`, 24'd1_000_000: cycles without a committed frame before `link_lost` asserts; legal range ≥ 1.
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `seg_sel` in 4: digit select, active-low one-cold; bit n is digit n. Asynchronous to `sys_clk`.
- `seg_led` in 8: segments, active-high; bit7 is the dot, bits6:0 are g..a. Asynchronous to `sys_clk`.
- `data_out` out 16: last committed frame; digit n occupies `[4n+3:4n]`.
- `point_out` out 4: last committed dot flags; bit n belongs to digit n.
- `data_valid` out 1: one-cycle pulse when `data_out`/`point_out` update.
- `pat_err` out 1: one-cycle pulse when a sampled segment pattern is not one of the 16 hex glyphs.
- `seq_err` out 1: one-cycle pulse when a digit is sampled a second time before the frame completes.
- `link_lost` out 1: level; high while no frame has been committed for `TIMEOUT_CYC` cycles.

## Operation
- **Input synchronisation:** `seg_sel` and `seg_led` each pass through a 2-flop synchroniser. All further logic uses the synchronised copies.
- **States:** IDLE, SETTLE, SAMPLED.
  - IDLE: the synchronised `seg_sel` is not exactly one-cold (4'b1111, or two or more zeros). The settle counter is held at 0. The block stays here until `seg_sel` becomes one-cold.
  - SETTLE: `seg_sel` is one-cold and unchanged since the previous cycle; the counter increments each cycle. When the counter reaches `SETTLE_CYC`, sample `seg_led` and go to SAMPLED.
  - SAMPLED: the current dwell has already been sampled. No further sample is taken until `seg_sel` changes.
  - Any change of synchronised `seg_sel`, in any state, clears the counter. The block then goes to SETTLE if the new value is one-cold, otherwise to IDLE.
- **Sample action:**
  - Reverse-decode `seg_led[6:0]` to a nibble. Glyph patterns (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
  - Any other pattern stores nibble 0 and pulses `pat_err`.
  - The nibble and `seg_led[7]` are written to shadow slot n, and seen bit n is set.
  - If seen bit n was already set, the shadow slot is still overwritten and `seq_err` pulses.
- **Commit:**
  - On the cycle after the sample that makes `seen` equal 4'b1111, the block copies the shadow registers to `data_out`/`point_out`, pulses `data_valid`, and clears `seen`.
  - A frame that contained a `pat_err` is still committed.
- **Watchdog:**
  - A counter clears on every commit and otherwise increments, saturating at `TIMEOUT_CYC`.
  - `link_lost` is high whenever the counter equals `TIMEOUT_CYC`. It clears on the same edge that `data_valid` asserts.
  - If digit selection stops (any state), `data_out` holds its last value and `link_lost` eventually asserts.

## Timing
- **Reset values:** `data_out`=16'h0000, `point_out`=4'b0000, `data_valid`=0, `pat_err`=0, `seq_err`=0, `link_lost`=0. Also cleared: `seen`=0, shadows=0, all counters 0, state IDLE, synchronisers 4'b1111 / 8'h00.
- **Reset mid-operation:** a partial frame is discarded and capture restarts from IDLE.
- **Latency:** from the first `sys_clk` edge at which a new `seg_sel` value is present on the pins:
  - the sample happens SETTLE_CYC+3 edges later;
  - `pat_err`/`seq_err` assert on the sample edge;
  - `data_valid` asserts SETTLE_CYC+4 edges later (fourth digit only).
- **Minimum dwell:** a dwell shorter than SETTLE_CYC+1 synchronised cycles is never sampled. This is not an error.
- **Digit order:** any order is accepted. Completion depends only on all four seen bits.
- **Simultaneous events:** a commit and a new sample on the same edge are legal. The new sample goes into the freshly cleared `seen`.
- `data_valid` is never high on two consecutive cycles.

## Configuration
- `SEG_CAPTURE_CHANGE_ONLY_EN` defined: at commit, `data_valid` pulses only if the new {`point_out`, `data_out`} differs from the current value. Registers and watchdog still update on every completed frame.
- Not defined: `data_valid` pulses on every completed frame.

## Test plan
- Drive the scan 1110/1101/1011/0111 with glyphs for 16'h1A2F, dots 4'b0100, 50 cycles per dwell. Required: `data_out`=16'h1A2F, `point_out`=4'b0100, one `data_valid` per frame at dwell-4 start + SETTLE_CYC+4.
- Digit-1 dwell carries `seg_led`=8'h00. Required: `pat_err` pulse, committed nibble 1 = 0.
- Order 0,1,0,2,3. Required: `seq_err` at the second digit-0 sample; commit after digit 3 using the later digit-0 value.
- Glitch dwells of SETTLE_CYC-1 cycles and `seg_sel`=4'b1100. Required: no sample and no error pulses.
- Stop scanning for `TIMEOUT_CYC` cycles. Required: `link_lost`=1; it clears on the next `data_valid`.
- Assert reset after 2 digits, then repeat a full frame of 16'h0000 under `SEG_CAPTURE_CHANGE_ONLY_EN`. Required: outputs return to reset values; no `data_valid` for the unchanged 16'h0000 frame.
